ahb_master: RTL and testbench

AHB_MASTER -- requirements
Module: ahb_master

---
 rtl/ahb_master.sv | 142 ++++++++++++++
 tb/tb_ahb_master.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master.sv
// AHB-Lite single-transfer master: a local command port feeds a one-deep address-phase
// slot and a one-deep data-phase slot, and responses come back in command order.
module ahb_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_hclk,
   input  logic                  i_hresetn,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic                  i_cmd_write,
   input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
   input  logic [2:0]            i_cmd_size,
   input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
   output logic                  o_rsp_valid,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                  o_rsp_error,
   output logic [ADDR_WIDTH-1:0] o_haddr,
   output logic                  o_hwrite,
   output logic [2:0]            o_hsize,
   output logic [1:0]            o_htrans,
   output logic [DATA_WIDTH-1:0] o_hwdata,
   input  logic                  i_hready,
   input  logic                  i_hresp,
   input  logic [DATA_WIDTH-1:0] i_hrdata
);

   typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_NONSEQ = 2'b10} htrans_e;

   logic                  ap_vld_q, ap_vld_d, ap_bad_q, ap_bad_d;
   logic [DATA_WIDTH-1:0] ap_wdata_q, ap_wdata_d;
   logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
   logic                  hwrite_q, hwrite_d;
   logic [2:0]            hsize_q, hsize_d;
   htrans_e               htrans_q, htrans_d;
   logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
   logic                  dp_vld_q, dp_vld_d, dp_bad_q, dp_bad_d, dp_write_q, dp_write_d;
   logic                  errhold_q, errhold_d;
   logic                  rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   logic       dp_real, accept, cmd_bad, ap_retire, dp_done, err_start;
   logic [1:0] align_mask;

   assign dp_real     = dp_vld_q & ~dp_bad_q;
   assign o_cmd_ready = i_hresetn & ~errhold_q & (~ap_vld_q | i_hready) & ~(i_hresp & dp_real);
   assign accept      = i_cmd_valid & o_cmd_ready;
   assign align_mask  = (i_cmd_size == 3'd2) ? 2'b11 : (i_cmd_size == 3'd1) ? 2'b01 : 2'b00;
   assign cmd_bad     = (i_cmd_size > 3'd2) | ((i_cmd_addr[1:0] & align_mask) != 2'b00);
   // An AP held by ERRHOLD was cancelled on the bus, so it must not slide into DP.
   assign ap_retire   = ap_vld_q & i_hready & ~errhold_q;
   assign dp_done     = dp_vld_q & i_hready;
   assign err_start   = dp_real & i_hresp & ~i_hready & ~errhold_q;

   always_comb begin
      ap_vld_d    = ap_vld_q;
      ap_bad_d    = ap_bad_q;
      ap_wdata_d  = ap_wdata_q;
      haddr_d     = haddr_q;
      hwrite_d    = hwrite_q;
      hsize_d     = hsize_q;
      hwdata_d    = hwdata_q;
      dp_vld_d    = dp_vld_q;
      dp_bad_d    = dp_bad_q;
      dp_write_d  = dp_write_q;
      errhold_d   = errhold_q;
      rsp_valid_d = dp_done;
      rsp_error_d = dp_done & (dp_bad_q | i_hresp);
      rsp_rdata_d = (dp_done & ~dp_bad_q & ~dp_write_q) ? i_hrdata : '0;

      if (dp_done) dp_vld_d = 1'b0;
      if (ap_retire) begin
         ap_vld_d   = 1'b0;
         dp_vld_d   = 1'b1;
         dp_bad_d   = ap_bad_q;
         dp_write_d = hwrite_q;
         if (!ap_bad_q) hwdata_d = hwrite_q ? ap_wdata_q : '0;
      end
      // Rejected commands ride the slots only to keep response order; the bus never sees them.
      if (accept) begin
         ap_vld_d   = 1'b1;
         ap_bad_d   = cmd_bad;
         ap_wdata_d = i_cmd_wdata;
         if (!cmd_bad) begin
            haddr_d  = i_cmd_addr;
            hwrite_d = i_cmd_write;
            hsize_d  = i_cmd_size;
         end
      end

      if (err_start)                  errhold_d = 1'b1;
      else if (errhold_q && i_hready) errhold_d = 1'b0;

      htrans_d = (ap_vld_d & ~ap_bad_d & ~errhold_d) ? HT_NONSEQ : HT_IDLE;
   end

   always_ff @(posedge i_hclk) begin
      if (!i_hresetn) begin
         ap_vld_q    <= 1'b0;
         ap_bad_q    <= 1'b0;
         ap_wdata_q  <= '0;
         haddr_q     <= '0;
         hwrite_q    <= 1'b0;
         hsize_q     <= 3'd0;
         htrans_q    <= HT_IDLE;
         hwdata_q    <= '0;
         dp_vld_q    <= 1'b0;
         dp_bad_q    <= 1'b0;
         dp_write_q  <= 1'b0;
         errhold_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         ap_vld_q    <= ap_vld_d;
         ap_bad_q    <= ap_bad_d;
         ap_wdata_q  <= ap_wdata_d;
         haddr_q     <= haddr_d;
         hwrite_q    <= hwrite_d;
         hsize_q     <= hsize_d;
         htrans_q    <= htrans_d;
         hwdata_q    <= hwdata_d;
         dp_vld_q    <= dp_vld_d;
         dp_bad_q    <= dp_bad_d;
         dp_write_q  <= dp_write_d;
         errhold_q   <= errhold_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign o_haddr     = haddr_q;
   assign o_hwrite    = hwrite_q;
   assign o_hsize     = hsize_q;
   assign o_htrans    = htrans_q;
   assign o_hwdata    = hwdata_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_error = rsp_error_q;

endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: AHB slave model with wait states and error regions, plus an
// in-order response scoreboard driven by a word-memory reference model.
module tb_ahb_master;
   logic        clk = 1'b0;
   logic        hresetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [2:0]  cmd_size;
   logic        rsp_valid, rsp_error;
   logic [31:0] rsp_rdata;
   logic [31:0] haddr, hwdata, hrdata;
   logic        hwrite, hready, hresp;
   logic [2:0]  hsize;
   logic [1:0]  htrans;

   ahb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .i_hclk(clk), .i_hresetn(hresetn),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
      .i_cmd_addr(cmd_addr), .i_cmd_size(cmd_size), .i_cmd_wdata(cmd_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_error(rsp_error),
      .o_haddr(haddr), .o_hwrite(hwrite), .o_hsize(hsize), .o_htrans(htrans),
      .o_hwdata(hwdata), .i_hready(hready), .i_hresp(hresp), .i_hrdata(hrdata));

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Slave: 0x100-0x17F answers with a two-cycle ERROR, 0x180-0x1FF with a one-cycle ERROR.
   int          min_w = 0, max_w = 0;
   logic [31:0] smem [16];
   logic        s_act, s_write, s_err, s_err1, s_eph;
   logic [3:0]  s_idx;
   int          s_wait;

   always_comb begin
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = '0;
      if (s_act) begin
         if (s_err) begin
            hresp  = 1'b1;
            hready = s_err1 | s_eph;
         end else if (s_wait > 0) hready = 1'b0;
         else if (!s_write) hrdata = smem[s_idx];
      end
   end

   always @(posedge clk) begin
      if (!hresetn) begin
         s_act <= 1'b0; s_write <= 1'b0; s_err <= 1'b0; s_err1 <= 1'b0; s_eph <= 1'b0;
         s_idx <= '0; s_wait <= 0;
         for (int k = 0; k < 16; k++) smem[k] <= '0;
      end else if (hready) begin
         if (s_act && s_write && !s_err) smem[s_idx] <= hwdata;
         if (htrans == 2'b10) begin
            s_act <= 1'b1; s_idx <= haddr[5:2]; s_write <= hwrite;
            s_err <= haddr[8]; s_err1 <= haddr[7]; s_eph <= 1'b0;
            s_wait <= $urandom_range(min_w, max_w);
         end else s_act <= 1'b0;
      end else begin
         if (s_err) s_eph <= 1'b1;
         else       s_wait <= s_wait - 1;
      end
   end

   // Reference: responses in command order, computed from a plain word memory.
   typedef struct { logic err; logic [31:0] rdata; } exp_t;
   exp_t        expq[$];
   logic [31:0] ref_mem [16];
   int          rsp_cnt = 0;

   function automatic exp_t model(input logic w, input logic [31:0] a, input logic [2:0] s,
                                  input logic [31:0] d);
      exp_t e;
      e.err = 1'b0; e.rdata = '0;
      if (s > 3'd2 || (a % (32'd1 << s)) != 0) e.err = 1'b1;
      else if (a >= 32'h100 && a < 32'h200) e.err = 1'b1;
      else if (w) ref_mem[a[5:2]] = d;
      else e.rdata = ref_mem[a[5:2]];
      return e;
   endfunction

   always @(negedge clk) begin
      if (hresetn && rsp_valid) begin
         rsp_cnt++;
         if (expq.size() == 0) chk("rsp_unexpected", 1, 0);
         else begin
            exp_t e;
            e = expq.pop_front();
            chk("rsp_error", rsp_error, e.err);
            chk("rsp_rdata", rsp_rdata, e.rdata);
         end
      end
   end

   // Bus monitor: a stalled NONSEQ keeps its address; nothing misaligned is ever issued.
   logic        p_rstn = 1'b0, p_ns = 1'b0, p_rdy = 1'b1, p_resp = 1'b0;
   logic [31:0] p_addr = '0;
   always @(negedge clk) begin
      if (hresetn && p_rstn && p_ns && !p_rdy && !p_resp) begin
         chk("hold_htrans", htrans, 2'b10);
         chk("hold_haddr", haddr, p_addr);
      end
      if (hresetn && htrans == 2'b10)
         chk("issued_aligned", (haddr % (32'd1 << hsize)) == 0 && hsize <= 3'd2, 1);
      p_rstn <= hresetn; p_ns <= (htrans == 2'b10); p_rdy <= hready;
      p_resp <= hresp;   p_addr <= haddr;
   end

   task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s,
                       input logic [31:0] d);
      int t = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
      #1;
      while (!cmd_ready && t < 200) begin
         @(negedge clk); #1; t++;
      end
      if (!cmd_ready) begin
         chk("cmd_ready_timeout", 0, 1);
         cmd_valid = 1'b0;
      end else begin
         expq.push_back(model(w, a, s, d));
         @(posedge clk);
      end
   endtask

   task automatic drain();
      int t = 0;
      @(negedge clk); cmd_valid = 1'b0;
      while (expq.size() != 0 && t < 1000) begin
         @(negedge clk); t++;
      end
      chk("drain_empty", expq.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      hresetn = 1'b0; cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      expq.delete();
      for (int k = 0; k < 16; k++) ref_mem[k] = '0;
      chk("rst_htrans", htrans, 2'b00);
      chk("rst_haddr", haddr, 0);
      chk("rst_hwdata", hwdata, 0);
      chk("rst_ctrl", {hwrite, hsize, rsp_valid, rsp_error}, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      @(negedge clk); hresetn = 1'b1;
   endtask

   initial begin
      int c0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
      do_reset();

      // Zero-wait write then read-back, latency 3
      send(1'b1, 32'h0, 3'd2, 32'hCAFEBABE);
      @(negedge clk); cmd_valid = 1'b0;
      chk("wr_ap_htrans", htrans, 2'b10);
      chk("wr_ap_addr", {hwrite, haddr}, {1'b1, 32'h0});
      @(negedge clk);
      chk("wr_dp_hwdata", hwdata, 32'hCAFEBABE);
      chk("wr_dp_norsp", rsp_valid, 0);
      @(negedge clk);
      chk("wr_rsp", {rsp_valid, rsp_error}, 2'b10);
      send(1'b0, 32'h0, 3'd2, 32'h0);
      @(negedge clk); cmd_valid = 1'b0;
      @(negedge clk);
      chk("rd_dp_hwdata", hwdata, 0);
      @(negedge clk);
      chk("rd_rsp", {rsp_valid, rsp_error, rsp_rdata}, {2'b10, 32'hCAFEBABE});
      drain();

      // Back-to-back writes with two wait states each
      min_w = 2; max_w = 2; c0 = rsp_cnt;
      send(1'b1, 32'h0, 3'd2, 32'h11111111);
      send(1'b1, 32'h4, 3'd2, 32'h22222222);
      send(1'b1, 32'h8, 3'd2, 32'h33333333);
      drain();
      chk("b2b_rsp_count", rsp_cnt - c0, 3);
      min_w = 0; max_w = 0;
      send(1'b0, 32'h4, 3'd2, 32'h0);
      drain();

      // ERROR on first of two pipelined reads: second is cancelled then re-issued
      send(1'b0, 32'h100, 3'd2, 32'h0);
      send(1'b0, 32'h8, 3'd2, 32'h0);
      @(negedge clk); cmd_valid = 1'b0;
      chk("err_ap2", {htrans, haddr}, {2'b10, 32'h8});
      @(negedge clk);
      chk("err_cycle2_idle", {htrans, haddr}, {2'b00, 32'h8});
      @(negedge clk);
      chk("err_reissue", {htrans, haddr}, {2'b10, 32'h8});
      drain();

      // One-cycle ERROR: reported, nothing cancelled
      send(1'b1, 32'h180, 3'd2, 32'h5);
      send(1'b0, 32'h0, 3'd2, 32'h0);
      drain();

      // Misaligned command never reaches the bus
      send(1'b1, 32'h2, 3'd2, 32'hDEAD);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); cmd_valid = 1'b0;
         chk("misalign_idle", htrans, 2'b00);
      end
      drain();

      // Reset while the data phase is stalled
      min_w = 3; max_w = 3; c0 = rsp_cnt;
      send(1'b1, 32'h8, 3'd2, 32'h77);
      @(negedge clk); cmd_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_stall", hready, 0);
      do_reset();
      repeat (6) @(negedge clk);
      chk("rst_no_rsp", rsp_cnt - c0, 0);

      // Randomized mix of sizes, alignments, regions, gaps and wait states
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         logic [2:0]  s;
         int r, g;
         if (i % 50 == 0) begin min_w = 0; max_w = $urandom_range(0, 2); end
         r = $urandom_range(0, 15);
         a = (r < 11) ? 32'h0 : (r < 13) ? 32'h100 : 32'h180;
         a = a + 32'($urandom_range(0, 15) * 4);
         r = $urandom_range(0, 9);
         s = (r == 0) ? 3'd0 : (r == 1) ? 3'd1 : (r == 9) ? 3'd3 : 3'd2;
         if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(0, 3));
         g = $urandom_range(0, 3);
         if (g > 1) begin
            @(negedge clk); cmd_valid = 1'b0;
            repeat (g - 2) @(negedge clk);
         end
         send(1'($urandom_range(0, 1)), a, s, $urandom);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
